mm_read_responder: RTL and testbench

MM_READ_RESPONDER -- requirements
Module: mm_read_responder

---
 rtl/mm_read_responder_pkg.sv | 17 +
 rtl/mm_resp_ram.sv | 26 ++
 rtl/mm_read_responder.sv | 120 ++++++++++++
 tb/tb_mm_read_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_read_responder_pkg.sv
// Shared types and default sizing for the memory-mapped read responder.
package mm_read_responder_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_LATENCY    = 4;
    localparam int ERR_CNT_W      = 8;
    localparam int LAT_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_BUSY,
        WR_BUSY
    } state_t;

endpackage

// File: rtl/mm_resp_ram.sv
// Single-port word store: synchronous write, combinational read.
module mm_resp_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset on purpose; clearing every word would need
    // a reset fan-out to the whole array and prevents mapping onto RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mm_read_responder.sv
// Memory-mapped slave: one outstanding command, fixed-latency read response,
// saturating count of erroneous commands.
module mm_read_responder
    import mm_read_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t                 state;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic [IDX_W-1:0]       addr_q;
    logic                   oor_q;

    logic                   accept;
    logic                   in_range;
    logic                   cmd_err;
    logic                   ram_we;
    logic [IDX_W-1:0]       ram_addr;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    assign in_range = ((address >> IDX_W) == '0);
    assign accept   = (state == IDLE) && !waitrequest && (read || write);
    assign cmd_err  = accept && (!in_range || (read && write));
    assign ram_we   = accept && write && !read && in_range;
    // The port follows the live bus while idle and the captured address while a read is pending.
    assign ram_addr = (state == IDLE) ? address[IDX_W-1:0] : addr_q;

    mm_resp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (writedata),
        .rdata (ram_rdata)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            waitrequest   <= 1'b1;
            readdatavalid <= 1'b0;
            readdata      <= '0;
            err_cnt       <= '0;
            lat_cnt       <= '0;
            addr_q        <= '0;
            oor_q         <= 1'b0;
        end else begin
            readdatavalid <= 1'b0;
            readdata      <= '0;

            if (cmd_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    waitrequest <= 1'b0;
                    if (accept) begin
                        waitrequest <= 1'b1;
                        addr_q      <= address[IDX_W-1:0];
                        oor_q       <= !in_range;
                        lat_cnt     <= LAT_CNT_W'(LATENCY - 1);
                        if (read) begin
                            state <= RD_BUSY;
                            if (LATENCY == 1) begin
                                readdatavalid <= 1'b1;
                                readdata      <= in_range ? ram_rdata : '0;
                            end
                        end else begin
                            state <= WR_BUSY;
                        end
                    end
                end
                RD_BUSY: begin
                    if (lat_cnt == '0) begin
                        state       <= IDLE;
                        waitrequest <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                        // Register the response so it is visible in the cycle the counter hits zero.
                        if (lat_cnt == LAT_CNT_W'(1)) begin
                            readdatavalid <= 1'b1;
                            readdata      <= oor_q ? '0 : ram_rdata;
                        end
                    end
                end
                WR_BUSY: begin
                    state       <= IDLE;
                    waitrequest <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_read_responder.sv
// Randomised and directed bench for mm_read_responder against a cycle-indexed
// transaction model (acceptance windows, due cycles, word array).
module tb_mm_read_responder;

    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] writedata = '0;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic [7:0]    err_cnt;

    mm_read_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycle k is the interval after the k-th rising edge.
    typedef struct {
        int          due;
        logic [63:0] data;
    } resp_t;

    resp_t       resp_q[$];
    logic [63:0] mem_m [DEPTH];
    int          cyc = 0;
    int          busy_until = 0;
    int          err_m = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            resp_q.delete();
            err_m      = 0;
            busy_until = cyc + 1;
        end else if (cyc > busy_until && (read || write)) begin
            logic ok;
            ok = (address < DEPTH);
            if (!ok || (read && write)) err_m = (err_m < 255) ? err_m + 1 : 255;
            if (read) begin
                resp_t r;
                r.due  = cyc + LAT;
                r.data = ok ? mem_m[address[3:0]] : 64'h0;
                resp_q.push_back(r);
                busy_until = cyc + LAT;
            end else begin
                if (ok) mem_m[address[3:0]] = writedata;
                busy_until = cyc + 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_waitrequest", waitrequest, 1);
            check("rst_readdatavalid", readdatavalid, 0);
            check("rst_readdata", readdata, 0);
            check("rst_err_cnt", err_cnt, 0);
        end else begin
            logic        exp_v;
            logic [63:0] exp_d;
            exp_v = 1'b0;
            exp_d = '0;
            if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
                resp_t r;
                r = resp_q.pop_front();
                exp_v = 1'b1;
                exp_d = r.data;
            end
            check($sformatf("cyc%0d_waitrequest", cyc), waitrequest, (cyc <= busy_until) ? 1 : 0);
            check($sformatf("cyc%0d_readdatavalid", cyc), readdatavalid, exp_v);
            check($sformatf("cyc%0d_readdata", cyc), readdata, exp_d);
            check($sformatf("cyc%0d_err_cnt", cyc), err_cnt, err_m);
        end
    end

    // Waits (bounded) for waitrequest low; returns the accept cycle or -1.
    task automatic wait_accept(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                t = cyc;
                break;
            end
        end
        check("accept_within_bound", (t >= 0) ? 1 : 0, 1);
    endtask

    task automatic cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int t);
        read      = rd;
        write     = wr;
        address   = a;
        writedata = d;
        wait_accept(t);
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Pins one read response: busy for LAT cycles, data only in the last one.
    task automatic watch_read(input string tag, input logic [DW-1:0] exp_data);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check($sformatf("%s_wait_T+%0d", tag, k), waitrequest, 1);
            check($sformatf("%s_valid_T+%0d", tag, k), readdatavalid, (k == LAT) ? 1 : 0);
            if (k == LAT) check($sformatf("%s_data", tag), readdata, exp_data);
        end
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] pre_data [DEPTH];

    initial begin
        int t, t1, t2;

        // Reset values and release timing
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_waitrequest", waitrequest, 1);
        check("reset_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("release_cycle_waitrequest", waitrequest, 1);
        @(negedge clk);
        check("after_release_waitrequest", waitrequest, 0);
        @(posedge clk);
        #1;

        // Fill every word with known data
        for (int i = 0; i < DEPTH; i++) begin
            pre_data[i] = (i == 3) ? 64'h0102030405060708 :
                          (i == 2) ? 64'h00000000000000AA : {$urandom, $urandom};
            cmd(1'b0, 1'b1, AW'(i), pre_data[i], t);
        end

        // Write then read addr 3
        cmd(1'b1, 1'b0, 32'd3, '0, t);
        watch_read("rd3", 64'h0102030405060708);

        // Back-to-back reads with read held high
        read    = 1'b1;
        address = 32'd0;
        wait_accept(t1);
        @(posedge clk);
        #1 address = 32'd1;
        wait_accept(t2);
        check("b2b_second_accept_gap", 64'(t2 - t1), 5);
        @(posedge clk);
        #1 read = 1'b0;
        watch_read("b2b_rd1", pre_data[1]);

        // Out-of-range read and write
        cmd(1'b1, 1'b0, 32'd16, '0, t);
        watch_read("rd16", 64'h0);
        check("oor_read_err_cnt", err_cnt, 1);
        cmd(1'b0, 1'b1, 32'd20, 64'hDEADBEEFDEADBEEF, t);
        @(negedge clk);
        check("oor_write_err_cnt", err_cnt, 2);
        @(posedge clk);
        #1;
        cmd(1'b1, 1'b0, 32'd4, '0, t);
        watch_read("rd4_unaliased", pre_data[4]);

        // read and write together
        cmd(1'b1, 1'b1, 32'd2, 64'h55, t);
        watch_read("rdwr2", 64'hAA);
        check("rdwr_err_cnt", err_cnt, 3);
        cmd(1'b1, 1'b0, 32'd2, '0, t);
        watch_read("rd2_after", 64'hAA);

        // Reset in the middle of a read
        cmd(1'b1, 1'b0, 32'd5, '0, t);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrd_reset_valid", readdatavalid, 0);
            check("midrd_reset_wait", waitrequest, 1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrd_release_wait", waitrequest, 1);
        check("midrd_release_valid", readdatavalid, 0);
        @(negedge clk);
        check("midrd_after_wait", waitrequest, 0);
        check("midrd_after_err", err_cnt, 0);
        @(posedge clk);
        #1;

        // Random traffic, inputs also wiggle while busy
        for (int i = 0; i < 500; i++) begin
            read      = ($urandom_range(0, 1) == 1);
            write     = ($urandom_range(0, 9) < 4);
            address   = ($urandom_range(0, 11) == 0) ? ($urandom | 32'h100) : AW'($urandom_range(0, 23));
            writedata = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        read  = 1'b0;
        write = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Saturation of the error counter
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 300; i++) cmd(1'b1, 1'b0, AW'(16 + (i % 8)), '0, t);
        @(negedge clk);
        check("err_cnt_saturated", err_cnt, 255);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) cmd(1'b1, 1'b0, 32'd17, '0, t);
        @(negedge clk);
        check("err_cnt_stays_255", err_cnt, 255);

        repeat (6) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
